// File: rtl/keyvalue_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | keyvalue_arbiter_pkg: shared types and constants for the arbiter   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package keyvalue_arbiter_pkg;

  localparam int KV_W = 16;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  function automatic logic [NREQ-1:0] owner_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keyvalue_rr_pick.sv
// +--------------------------------------------------------------------+
// | keyvalue_rr_pick: 2-way round-robin pick from requests/last grant  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module keyvalue_rr_pick
  import keyvalue_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic            last_i,
  output logic            pick_o,
  output logic            valid_o
);

  always_comb begin
    valid_o = |req_i;
    pick_o  = last_i;
    if (req_i[~last_i]) begin
      pick_o = ~last_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/keyvalue_arbiter.sv
// +--------------------------------------------------------------------+
// | keyvalue_arbiter: 2-requester arbiter in front of a key/value store|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module keyvalue_arbiter
  import keyvalue_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NREQ-1:0]      m_CYC_i,
  input  logic [NREQ-1:0]      m_STB_i,
  input  logic [NREQ-1:0]      m_WE_i,
  input  logic [NREQ*KV_W-1:0] m_ADR_i,
  input  logic [NREQ*KV_W-1:0] m_DAT_i,
  input  logic [NREQ*KV_W-1:0] m_KEY_i,
  output logic [NREQ-1:0]      m_GNT_o,
  output logic [NREQ-1:0]      m_STALL_o,
  output logic [NREQ-1:0]      m_ACK_o,
  output logic [KV_W-1:0]      m_DAT_o,
  output logic                 s_CYC_o,
  output logic                 s_STB_o,
  output logic                 s_WE_o,
  output logic [KV_W-1:0]      s_ADR_o,
  output logic [KV_W-1:0]      s_DAT_o,
  output logic [KV_W-1:0]      s_KEY_o,
  output logic                 s_RESET_o,
  input  logic                 s_STALL_i,
  input  logic                 s_ACK_i,
  input  logic [KV_W-1:0]      s_DAT_i,
  output logic                 timeout_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic            pick;
  logic            pick_valid;
  logic            own_cyc, own_stb, own_we;
  logic [KV_W-1:0] own_adr, own_dat, own_key;

  keyvalue_rr_pick u_pick (
    .req_i   (m_CYC_i),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  assign own_cyc = owner_q ? m_CYC_i[1] : m_CYC_i[0];
  assign own_stb = owner_q ? m_STB_i[1] : m_STB_i[0];
  assign own_we  = owner_q ? m_WE_i[1]  : m_WE_i[0];
  assign own_adr = owner_q ? m_ADR_i[KV_W +: KV_W] : m_ADR_i[0 +: KV_W];
  assign own_dat = owner_q ? m_DAT_i[KV_W +: KV_W] : m_DAT_i[0 +: KV_W];
  assign own_key = owner_q ? m_KEY_i[KV_W +: KV_W] : m_KEY_i[0 +: KV_W];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick;
          last_d  = pick;
          cnt_d   = 16'd0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        // A release on the timeout cycle takes the clean DRAIN path.
        if (!own_cyc) begin
          state_d = ST_DRAIN;
        end else if (cnt_q >= TO_LAST) begin
          state_d   = ST_ABORT;
          timeout_d = 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_CYC_o   = 1'b0;
    s_STB_o   = 1'b0;
    s_WE_o    = 1'b0;
    s_ADR_o   = '0;
    s_DAT_o   = '0;
    s_KEY_o   = '0;
    s_RESET_o = 1'b0;
    m_GNT_o   = '0;
    m_STALL_o = '1;
    m_ACK_o   = '0;
    case (state_q)
      ST_GRANT: begin
        s_CYC_o            = own_cyc;
        s_STB_o            = own_cyc & own_stb;
        s_WE_o             = own_cyc & own_we;
        s_ADR_o            = own_adr;
        s_DAT_o            = own_dat;
        s_KEY_o            = own_key;
        m_GNT_o            = owner_onehot(owner_q);
        m_STALL_o[owner_q] = s_STALL_i;
        m_ACK_o[owner_q]   = s_ACK_i;
      end
      ST_DRAIN: begin
        // The store may ack a read after CYC has dropped.
        m_GNT_o          = owner_onehot(owner_q);
        m_ACK_o[owner_q] = s_ACK_i;
      end
      ST_ABORT: begin
        m_GNT_o   = owner_onehot(owner_q);
        s_RESET_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_DAT_o   = s_DAT_i;
  assign timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_keyvalue_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_keyvalue_arbiter: directed self-checking bench for the arbiter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_keyvalue_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  m_CYC_i, m_STB_i, m_WE_i;
  logic [31:0] m_ADR_i, m_DAT_i, m_KEY_i;
  logic [1:0]  m_GNT_o, m_STALL_o, m_ACK_o;
  logic [15:0] m_DAT_o;
  logic        s_CYC_o, s_STB_o, s_WE_o;
  logic [15:0] s_ADR_o, s_DAT_o, s_KEY_o;
  logic        s_RESET_o;
  logic        s_STALL_i, s_ACK_i;
  logic [15:0] s_DAT_i;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  keyvalue_arbiter #(.TIMEOUT(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_CYC_i   (m_CYC_i),
    .m_STB_i   (m_STB_i),
    .m_WE_i    (m_WE_i),
    .m_ADR_i   (m_ADR_i),
    .m_DAT_i   (m_DAT_i),
    .m_KEY_i   (m_KEY_i),
    .m_GNT_o   (m_GNT_o),
    .m_STALL_o (m_STALL_o),
    .m_ACK_o   (m_ACK_o),
    .m_DAT_o   (m_DAT_o),
    .s_CYC_o   (s_CYC_o),
    .s_STB_o   (s_STB_o),
    .s_WE_o    (s_WE_o),
    .s_ADR_o   (s_ADR_o),
    .s_DAT_o   (s_DAT_o),
    .s_KEY_o   (s_KEY_o),
    .s_RESET_o (s_RESET_o),
    .s_STALL_i (s_STALL_i),
    .s_ACK_i   (s_ACK_i),
    .s_DAT_i   (s_DAT_i),
    .timeout_o (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    m_CYC_i   = 2'b11;
    m_STB_i   = 2'b11;
    m_WE_i    = 2'b00;
    m_ADR_i   = 32'h0;
    m_DAT_i   = 32'h0;
    m_KEY_i   = 32'h0;
    s_STALL_i = 1'b0;
    s_ACK_i   = 1'b1;
    s_DAT_i   = 16'h0;
    #3;
    chk("rst_gnt",     32'(m_GNT_o),   32'h0);
    chk("rst_stall",   32'(m_STALL_o), 32'h3);
    chk("rst_ack",     32'(m_ACK_o),   32'h0);
    chk("rst_scyc",    32'(s_CYC_o),   32'h0);
    chk("rst_sreset",  32'(s_RESET_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    s_ACK_i = 1'b0;
    m_CYC_i = 2'b00;
    m_STB_i = 2'b00;
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;

    // single write by m0; m1 lanes carry distinct values that must not leak
    m_CYC_i = 2'b01; m_STB_i = 2'b01; m_WE_i = 2'b01;
    m_ADR_i = 32'h5555_0000; m_DAT_i = 32'h6666_00AA; m_KEY_i = 32'h7777_0011;
    #1;
    chk("w_idle_gnt", 32'(m_GNT_o), 32'h0);
    tick();
    chk("w_gnt",  32'(m_GNT_o), 32'h1);
    chk("w_scyc", 32'(s_CYC_o), 32'h1);
    chk("w_sstb", 32'(s_STB_o), 32'h1);
    chk("w_swe",  32'(s_WE_o),  32'h1);
    chk("w_sadr", 32'(s_ADR_o), 32'h0000);
    chk("w_sdat", 32'(s_DAT_o), 32'h00AA);
    chk("w_skey", 32'(s_KEY_o), 32'h0011);
    s_STALL_i = 1'b1; #1;
    chk("w_stall_hi", 32'(m_STALL_o), 32'h3);
    s_STALL_i = 1'b0; #1;
    chk("w_stall_lo", 32'(m_STALL_o), 32'h2);
    s_ACK_i = 1'b1; #1;
    chk("w_ack", 32'(m_ACK_o), 32'h1);
    s_ACK_i = 1'b0;
    m_CYC_i = 2'b00; m_STB_i = 2'b00; m_WE_i = 2'b00; #1;
    chk("w_drop_scyc", 32'(s_CYC_o), 32'h0);
    tick();
    chk("w_drain_gnt",  32'(m_GNT_o), 32'h1);
    chk("w_drain_sadr", 32'(s_ADR_o), 32'h0);
    s_ACK_i = 1'b1; #1;
    chk("w_drain_ack", 32'(m_ACK_o), 32'h1);
    tick();
    chk("w_idle_gnt2", 32'(m_GNT_o), 32'h0);
    chk("w_idle_ack",  32'(m_ACK_o), 32'h0);
    s_ACK_i = 1'b0;

    // simultaneous requests after a fresh reset: m0 first, then m1
    sys_rst_n = 1'b0; #1;
    sys_rst_n = 1'b1;
    m_CYC_i = 2'b11; m_STB_i = 2'b11; m_WE_i = 2'b00;
    m_ADR_i = 32'h0002_0040;
    tick();
    chk("s_gnt0", 32'(m_GNT_o), 32'h1);
    s_ACK_i = 1'b1; #1;
    chk("s_ack_owner_only", 32'(m_ACK_o),   32'h1);
    chk("s_nonowner_stall", 32'(m_STALL_o), 32'h2);
    s_ACK_i = 1'b0;
    m_CYC_i = 2'b10; m_STB_i = 2'b10;
    tick();
    chk("s_drain_gnt", 32'(m_GNT_o), 32'h1);
    tick();
    chk("s_gap_gnt",  32'(m_GNT_o), 32'h0);
    chk("s_gap_scyc", 32'(s_CYC_o), 32'h0);
    tick();
    chk("s_gnt1", 32'(m_GNT_o), 32'h2);

    // m1 read at address 2, data returned during DRAIN
    chk("r_sadr", 32'(s_ADR_o), 32'h0002);
    chk("r_swe",  32'(s_WE_o),  32'h0);
    chk("r_sstb", 32'(s_STB_o), 32'h1);
    m_CYC_i = 2'b00; m_STB_i = 2'b00;
    tick();
    s_ACK_i = 1'b1; s_DAT_i = 16'h1234; #1;
    chk("r_ack", 32'(m_ACK_o), 32'h2);
    chk("r_dat", 32'(m_DAT_o), 32'h1234);
    s_ACK_i = 1'b0;
    tick();

    // m0 holds past TIMEOUT=8 while m1 waits
    m_CYC_i = 2'b01; m_STB_i = 2'b01;
    tick();
    m_CYC_i = 2'b11; m_STB_i = 2'b11; #1;
    chk("t_gnt0", 32'(m_GNT_o), 32'h1);
    chk("t_m1_stall", 32'(m_STALL_o[1]), 32'h1);
    repeat (7) tick();
    chk("t_c8_sreset", 32'(s_RESET_o), 32'h0);
    chk("t_c8_scyc",   32'(s_CYC_o),   32'h1);
    chk("t_c8_gnt",    32'(m_GNT_o),   32'h1);
    tick();
    s_ACK_i = 1'b1; #1;
    chk("t_ab_sreset", 32'(s_RESET_o), 32'h1);
    chk("t_ab_tmo",    32'(timeout_o), 32'h1);
    chk("t_ab_ack",    32'(m_ACK_o),   32'h0);
    chk("t_ab_stall",  32'(m_STALL_o), 32'h3);
    chk("t_ab_scyc",   32'(s_CYC_o),   32'h0);
    s_ACK_i = 1'b0;
    tick();
    chk("t_idle_sreset", 32'(s_RESET_o), 32'h0);
    chk("t_idle_tmo",    32'(timeout_o), 32'h1);
    chk("t_idle_gnt",    32'(m_GNT_o),   32'h0);
    tick();
    chk("t_gnt1", 32'(m_GNT_o), 32'h2);

    // asynchronous reset while m1 owns the store
    s_ACK_i = 1'b1; #1;
    chk("a_ack_pre", 32'(m_ACK_o), 32'h2);
    sys_rst_n = 1'b0; #1;
    chk("a_scyc",  32'(s_CYC_o),   32'h0);
    chk("a_gnt",   32'(m_GNT_o),   32'h0);
    chk("a_ack",   32'(m_ACK_o),   32'h0);
    chk("a_tmo",   32'(timeout_o), 32'h0);
    s_ACK_i = 1'b0;
    sys_rst_n = 1'b1;
    tick();
    chk("a_gnt0", 32'(m_GNT_o), 32'h1);

    // release on the timeout cycle wins over abort; m1 then wins
    repeat (7) tick();
    m_CYC_i = 2'b10; m_STB_i = 2'b10; #1;
    chk("d_scyc", 32'(s_CYC_o), 32'h0);
    tick();
    s_ACK_i = 1'b1; #1;
    chk("d_sreset", 32'(s_RESET_o), 32'h0);
    chk("d_gnt",    32'(m_GNT_o),   32'h1);
    chk("d_ack",    32'(m_ACK_o),   32'h1);
    chk("d_tmo",    32'(timeout_o), 32'h0);
    s_ACK_i = 1'b0;
    tick();
    chk("d_idle_gnt", 32'(m_GNT_o), 32'h0);
    tick();
    chk("d_gnt1", 32'(m_GNT_o), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
